serial_latch_loader: RTL and testbench

//  Upstream feeder for the D-latch bank. Collects a WIDTH-bit word from a serial input,

---
 rtl/serial_latch_loader.sv | 155 +++++++++++++++
 tb/tb_serial_latch_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_latch_loader.sv
// -----------------------------------------------------------------------------
// serial_latch_loader
//
// Front end for a bank of D-latches. A WIDTH-bit word is shifted in serially,
// MSB first. It is then driven on d_out while the latch enable e_out is pulsed
// high for STROBE_CYCLES cycles. d_out is registered on the same edge that
// raises e_out, so the latches see settled data before they open. d_out does not
// change while e_out is high, or in the cycle after e_out falls.
//
// Optional feature (compile-time macro PARITY_EN):
//   When defined, one even-parity bit follows the data word. A matching bit
//   strobes the word as usual. A mismatching bit pulses par_err, returns to
//   IDLE, and does not change d_out or e_out. When undefined, par_err is
//   tied to 0.
//
// Parameters:
//   WIDTH          bits per word (>=2)
//   STROBE_CYCLES  cycles e_out stays high per load (>=1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin a new load (sampled only in IDLE)
//   sin        in   serial data bit, MSB first
//   sin_valid  in   sin is valid this cycle
//   d_out      out  word presented to the latch D inputs
//   e_out      out  latch enable
//   busy       out  high whenever the loader is not IDLE
//   done       out  one-cycle pulse when a load completes
//   par_err    out  one-cycle pulse on parity mismatch
// -----------------------------------------------------------------------------
module serial_latch_loader #(
  parameter int WIDTH         = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] d_out,
  output logic             e_out,
  output logic             busy,
  output logic             done,
  output logic             par_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [SW-1:0] STB_LAST = SW'(STROBE_CYCLES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SHIFT  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
`ifdef PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    stb_cnt;
  logic [WIDTH-1:0] shreg;

  // busy comes straight from the state register, so it needs no reset logic of its own.
  assign busy = (state != IDLE);

`ifndef PARITY_EN
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      stb_cnt <= '0;
      d_out   <= '0;
      e_out   <= 1'b0;
      done    <= 1'b0;
`ifdef PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
`ifdef PARITY_EN
      par_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            shreg <= '0;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // The full word is collected. Leave SHIFT one edge after the last bit.
          if (cnt == CNT_FULL) begin
`ifdef PARITY_EN
            state <= PARITY;
`else
            // d_out and e_out update on the same edge, so D settles before E opens.
            d_out   <= shreg;
            e_out   <= 1'b1;
            stb_cnt <= '0;
            state   <= STROBE;
`endif
          end else if (sin_valid) begin
            shreg <= {shreg[WIDTH-2:0], sin};
            cnt   <= cnt + 1'b1;
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          if (sin_valid) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            if (sin == ^shreg) begin
              d_out   <= shreg;
              e_out   <= 1'b1;
              stb_cnt <= '0;
              state   <= STROBE;
            end else begin
              par_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end
`endif

        STROBE: begin
          if (stb_cnt == STB_LAST) begin
            e_out <= 1'b0;
            done  <= 1'b1;
            state <= HOLD;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end

        HOLD: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_latch_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_latch_loader
//
// Directed bench for serial_latch_loader (WIDTH=8, STROBE_CYCLES=2).
// The stimulus process pushes each expected load outcome into a queue. The
// monitor process pops an entry on every done or par_err pulse, compares the
// outcome, and also checks the shape of every e_out pulse.
// -----------------------------------------------------------------------------
module tb_serial_latch_loader;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sin;
  logic         sin_valid;
  logic [W-1:0] d_out;
  logic         e_out;
  logic         busy;
  logic         done;
  logic         par_err;

  serial_latch_loader #(.WIDTH(W), .STROBE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .d_out     (d_out),
    .e_out     (e_out),
    .busy      (busy),
    .done      (done),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           perr;   // outcome is a parity error rather than a strobe
    logic [W-1:0] word;   // d_out required at the done/par_err pulse
    bit           lat;    // gap-free load: check the busy duration
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  int bcnt   = 0;
  int scnt   = 0;
  logic [W-1:0] d_rise;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt = 0;
      scnt = 0;
    end else begin
      if (busy) bcnt++;
      else bcnt = 0;

      if (e_out) begin
        chk("strobe_expected", q.size() > 0, 1);
        chk("strobe_without_done", done, 0);
        if (scnt == 0) d_rise = d_out;
        else chk("d_stable_while_e", d_out, d_rise);
        scnt++;
      end

      if (done) begin
        dones++;
        chk("done_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("done_kind", e.perr, 0);
          chk("d_out_at_done", d_out, e.word);
          chk("strobe_len", scnt, S);
          chk("e_low_in_hold", e_out, 0);
          if (e.lat) chk("busy_cycles", bcnt, W + S + 2);
        end
        scnt = 0;
      end

      if (par_err) begin
        chk("perr_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("perr_kind", e.perr, 1);
          chk("d_out_kept_on_perr", d_out, e.word);
          chk("no_strobe_on_perr", scnt, 0);
          chk("e_low_on_perr", e_out, 0);
          chk("no_done_on_perr", done, 0);
        end
      end
    end
  end

  // Stimulus helpers. Inputs are driven on the falling edge.
  task automatic send_bits(input logic [W-1:0] w, input logic [W-1:0] gaps,
                           input bit poke, input int nbits);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (gaps[W-1-i]) begin
        sin_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      sin       = w[W-1-i];
      sin_valid = 1'b1;
      if (poke && i == 3) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    sin_valid = 1'b0;
  endtask

  task automatic send_parity(input logic p);
    @(negedge clk);
    sin       = p;
    sin_valid = 1'b1;
    @(negedge clk);
    sin_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d_out"},   d_out,   0);
    chk({tag, "_e_out"},   e_out,   0);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_done"},    done,    0);
    chk({tag, "_par_err"}, par_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // T2: gap-free load of A5
    q.push_back('{perr: 1'b0, word: 8'hA5, lat: 1'b1});
    send_bits(8'hA5, 8'h00, 1'b0, 8);
    wait_idle();

    // T3: load of 3C with sin_valid gaps
    q.push_back('{perr: 1'b0, word: 8'h3C, lat: 1'b0});
    send_bits(8'h3C, 8'b0110_1101, 1'b0, 8);
    wait_idle();

    // T1: reset held for two cycles partway through a load
    send_bits(8'h55, 8'h00, 1'b0, 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b0;
    @(negedge clk);

    // T4: start pulsed during SHIFT and during STROBE of FF
    q.push_back('{perr: 1'b0, word: 8'hFF, lat: 1'b0});
    send_bits(8'hFF, 8'h00, 1'b1, 8);
    n = 0;
    while (!e_out && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", e_out, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("single_done_after_pokes", dones, 3);
    chk("idle_after_pokes", busy, 0);

    q.push_back('{perr: 1'b0, word: 8'h00, lat: 1'b1});
    send_bits(8'h00, 8'h00, 1'b0, 8);
    wait_idle();

    // T5: reset at bit 5 of 81, then a full load of 7E
    send_bits(8'h81, 8'h00, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_e_out", e_out, 0);
    chk("abort_d_out", d_out, 0);
    chk("abort_busy", busy, 0);
    q.push_back('{perr: 1'b0, word: 8'h7E, lat: 1'b1});
    send_bits(8'h7E, 8'h00, 1'b0, 8);
    wait_idle();

`ifdef PARITY_EN
    // T6: parity match strobes; parity mismatch keeps the prior word
    q.push_back('{perr: 1'b0, word: 8'hA5, lat: 1'b0});
    send_bits(8'hA5, 8'h00, 1'b0, 8);
    send_parity(1'b0);
    wait_idle();
    q.push_back('{perr: 1'b1, word: 8'hA5, lat: 1'b0});
    send_bits(8'h3C, 8'h00, 1'b0, 8);
    send_parity(1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("done_total", dones, 6);
`else
    repeat (3) @(negedge clk);
    chk("par_err_tied_low", par_err, 0);
    chk("done_total", dones, 5);
`endif

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
